// File: rtl/fft256_frame_ctrl_if.sv
// Control bus of the 256-point FFT frame sequencer: the input sample stream,
// butterfly stage control, buffer RAM strobes and the framed output stream.
interface fft256_frame_ctrl_if #(
  parameter int LOGN = 8
);
  // Handshake: a sample moves on any clock edge where valid_in is high.
  // ready_in is high only while the sequencer is idle or loading. A sample
  // offered while ready_in is low is dropped, and a one-cycle overflow
  // pulse follows it.
  logic            valid_in;
  logic            sop_in;
  logic            inv_in;
  logic            ready_in;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr;
  logic            stage_en;
  logic [2:0]      stage_idx;
  logic [LOGN-1:0] tw_step;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr;
  logic            valid_out;
  logic            sop_out;
  logic            eop_out;
  logic            inv_out;
  logic            busy;
  logic            err_sop;
  logic            overflow;
  logic [1:0]      state_dbg;

  modport master (
    output valid_in, sop_in, inv_in,
    input  ready_in, wr_en, wr_addr, stage_en, stage_idx, tw_step, rd_en, rd_addr,
    input  valid_out, sop_out, eop_out, inv_out, busy, err_sop, overflow, state_dbg
  );

  modport slave (
    input  valid_in, sop_in, inv_in,
    output ready_in, wr_en, wr_addr, stage_en, stage_idx, tw_step, rd_en, rd_addr,
    output valid_out, sop_out, eop_out, inv_out, busy, err_sop, overflow, state_dbg
  );
endinterface

// File: rtl/fft256_frame_ctrl.sv
// Frame sequencer for the radix-2 FFT: loads a frame into the working buffer,
// steps the butterfly stages, then reads the frame out with sop/eop framing.
module fft256_frame_ctrl #(
  parameter int N         = 256,
  parameter int LOGN      = 8,
  parameter int STAGE_LAT = 2,
  parameter int BITREV    = 1
) (
  input logic                clk,
  input logic                rst,
  fft256_frame_ctrl_if.slave bus
);
  localparam int              LW       = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [LOGN-1:0] LAST     = LOGN'(N - 1);
  localparam logic [2:0]      LAST_STG = 3'(LOGN - 1);
  localparam logic [LW-1:0]   LAST_LAT = LW'(STAGE_LAT - 1);
  localparam logic [LOGN-1:0] TW0      = {1'b1, {(LOGN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, UNLOAD} state_t;

  state_t          state, nxt_state;
  logic [LOGN-1:0] cnt, nxt_cnt;
  logic [2:0]      stg, nxt_stg;
  logic [LW-1:0]   lat, nxt_lat;

  logic            ready_q, wr_en_q, stage_en_q, rd_en_q, valid_q, sop_q, eop_q;
  logic            inv_q, busy_q, err_q, ovf_q;
  logic [LOGN-1:0] wr_addr_q, rd_addr_q;
  logic [2:0]      stage_idx_q;

  logic            nxt_ready, nxt_wr_en, nxt_stage_en, nxt_rd_en;
  logic            nxt_inv, nxt_busy, nxt_err, nxt_ovf;
  logic [LOGN-1:0] nxt_wr_addr, nxt_rd_addr;
  logic [2:0]      nxt_stage_idx;

  function automatic logic [LOGN-1:0] addr_of(input logic [LOGN-1:0] c);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) r[i] = c[LOGN-1-i];
    return (BITREV != 0) ? r : c;
  endfunction

  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    nxt_stg       = stg;
    nxt_lat       = lat;
    nxt_wr_en     = 1'b0;
    nxt_wr_addr   = '0;
    nxt_stage_en  = 1'b0;
    nxt_stage_idx = '0;
    nxt_rd_en     = 1'b0;
    nxt_rd_addr   = '0;
    nxt_err       = 1'b0;
    nxt_ovf       = 1'b0;
    // The inverse flag belongs to the frame in flight; it drops after eop.
    nxt_inv       = eop_q ? 1'b0 : inv_q;
    unique case (state)
      IDLE: begin
        if (bus.valid_in && bus.sop_in) begin
          nxt_wr_en = 1'b1;
          nxt_inv   = bus.inv_in;
          nxt_cnt   = LOGN'(1);
          nxt_state = LOAD;
        end else if (bus.valid_in) begin
          nxt_err = 1'b1;
        end
      end
      LOAD: begin
        if (bus.valid_in) begin
          nxt_wr_en = 1'b1;
          if (bus.sop_in) begin
            nxt_cnt = LOGN'(1);
            nxt_inv = bus.inv_in;
            nxt_err = 1'b1;
          end else begin
            nxt_wr_addr = addr_of(cnt);
            if (cnt == LAST) begin
              nxt_cnt   = '0;
              nxt_stg   = '0;
              nxt_lat   = '0;
              nxt_state = COMPUTE;
            end else begin
              nxt_cnt = cnt + 1'b1;
            end
          end
        end
      end
      COMPUTE: begin
        // stg/lat describe the stage cycle presented on the next clock.
        nxt_ovf       = bus.valid_in;
        nxt_stage_en  = (lat == '0);
        nxt_stage_idx = stg;
        if (lat == LAST_LAT) begin
          nxt_lat = '0;
          if (stg == LAST_STG) begin
            nxt_stg   = '0;
            nxt_state = UNLOAD;
          end else begin
            nxt_stg = stg + 3'd1;
          end
        end else begin
          nxt_lat = lat + 1'b1;
        end
      end
      UNLOAD: begin
        nxt_ovf = bus.valid_in;
        if (rd_en_q && (rd_addr_q == LAST)) begin
          nxt_state = IDLE;
        end else begin
          nxt_rd_en   = 1'b1;
          nxt_rd_addr = rd_en_q ? rd_addr_q + 1'b1 : '0;
        end
      end
      default: nxt_state = IDLE;
    endcase
    nxt_ready = (nxt_state == IDLE) || (nxt_state == LOAD);
    nxt_busy  = (nxt_state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      stg         <= '0;
      lat         <= '0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      stage_en_q  <= 1'b0;
      stage_idx_q <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      inv_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      stg         <= nxt_stg;
      lat         <= nxt_lat;
      ready_q     <= nxt_ready;
      wr_en_q     <= nxt_wr_en;
      wr_addr_q   <= nxt_wr_addr;
      stage_en_q  <= nxt_stage_en;
      stage_idx_q <= nxt_stage_idx;
      rd_en_q     <= nxt_rd_en;
      rd_addr_q   <= nxt_rd_addr;
      // Buffer RAM answers one cycle after the read strobe.
      valid_q     <= rd_en_q;
      sop_q       <= rd_en_q && (rd_addr_q == '0);
      eop_q       <= rd_en_q && (rd_addr_q == LAST);
      inv_q       <= nxt_inv;
      busy_q      <= nxt_busy;
      err_q       <= nxt_err;
      ovf_q       <= nxt_ovf;
    end
  end

  assign bus.ready_in  = ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.stage_en  = stage_en_q;
  assign bus.stage_idx = stage_idx_q;
  assign bus.tw_step   = TW0 >> stage_idx_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.valid_out = valid_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;
  assign bus.inv_out   = inv_q;
  assign bus.busy      = busy_q;
  assign bus.err_sop   = err_q;
  assign bus.overflow  = ovf_q;
  assign bus.state_dbg = state;
endmodule
